// File: rtl/viterbi_ber_checker_if.sv
// Stimulus bundle for viterbi_ber_checker: start strobe plus
// reference and decoded bit streams with their valid qualifiers.
interface viterbi_ber_checker_if;
  logic start_i;
  logic ref_bit_i;
  logic ref_valid_i;
  logic dec_bit_i;
  logic dec_valid_i;

  modport master (
    output start_i,
    output ref_bit_i,
    output ref_valid_i,
    output dec_bit_i,
    output dec_valid_i
  );

  modport slave (
    input start_i,
    input ref_bit_i,
    input ref_valid_i,
    input dec_bit_i,
    input dec_valid_i
  );
endinterface

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker: reference FIFO, warm-up skip, windowed counts.
// Define BER_BURST_STATS_EN to add max_burst_o (longest mismatch run).
module viterbi_ber_checker #(
  parameter int DEPTH  = 64,
  parameter int SKIP   = 0,
  parameter int WINDOW = 256,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_ber_checker_if.slave bus,
  output logic [CW-1:0]        bit_ct_o,
  output logic [CW-1:0]        err_ct_o,
  output logic                 err_pulse_o,
  output logic                 done_o,
  output logic                 fifo_ovf_o,
  output logic                 fifo_unf_o
`ifdef BER_BURST_STATS_EN
  ,
  output logic [CW-1:0]        max_burst_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CT  = DEPTH[AW:0];
  localparam logic [CW-1:0] WIN       = CW'(WINDOW);
  localparam logic [CW-1:0] CMAX      = '1;
  localparam logic [31:0]   SKIP_LAST = 32'(SKIP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     skip_q, skip_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   err_q, err_d;
  logic            pulse_q, pulse_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
`ifdef BER_BURST_STATS_EN
  logic [CW-1:0]   run_q, run_d;
  logic [CW-1:0]   max_q, max_d;
`endif

  logic            mem_q [DEPTH];
  logic            push_ok;
  logic            pop_ok;
  logic            active;
  logic            empty;
  logic            full;
  logic            mis;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  assign active = (state_q == SYNC) || (state_q == RUN);
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_CT);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    bit_d   = bit_q;
    err_d   = err_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    mis     = 1'b0;
`ifdef BER_BURST_STATS_EN
    run_d   = run_q;
    max_d   = max_q;
`endif
    if (bus.start_i) begin
      state_d = (SKIP == 0) ? RUN : SYNC;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      skip_d  = '0;
      bit_d   = '0;
      err_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
`ifdef BER_BURST_STATS_EN
      run_d   = '0;
      max_d   = '0;
`endif
    end else if (active) begin
      pop_ok  = bus.dec_valid_i && !empty;
      push_ok = bus.ref_valid_i && (!full || pop_ok);
      if (bus.dec_valid_i && empty)
        unf_d = 1'b1;
      if (bus.ref_valid_i && !push_ok)
        ovf_d = 1'b1;
      if (push_ok)
        wr_d = wr_q + 1'b1;
      if (pop_ok)
        rd_d = rd_q + 1'b1;
      if (push_ok && !pop_ok)
        cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok)
        cnt_d = cnt_q - 1'b1;
      if (pop_ok) begin
        if (state_q == SYNC) begin
          skip_d = skip_q + 1'b1;
          if (skip_q == SKIP_LAST)
            state_d = RUN;
        end else begin
          mis   = mem_q[rd_q] ^ bus.dec_bit_i;
          bit_d = sat_inc(bit_q);
          if (mis) begin
            err_d   = sat_inc(err_q);
            pulse_d = 1'b1;
          end
`ifdef BER_BURST_STATS_EN
          if (mis) begin
            run_d = sat_inc(run_q);
            if (run_d > max_q)
              max_d = run_d;
          end else begin
            run_d = '0;
          end
`endif
          if (bit_d == WIN) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_q] <= bus.ref_bit_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      skip_q  <= '0;
      bit_q   <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef BER_BURST_STATS_EN
      run_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef BER_BURST_STATS_EN
      run_q   <= run_d;
      max_q   <= max_d;
`endif
    end
  end

  assign bit_ct_o    = bit_q;
  assign err_ct_o    = err_q;
  assign err_pulse_o = pulse_q;
  assign done_o      = done_q;
  assign fifo_ovf_o  = ovf_q;
  assign fifo_unf_o  = unf_q;
`ifdef BER_BURST_STATS_EN
  assign max_burst_o = max_q;
`endif

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter DEPTH, default 64, reference-bit FIFO depth; power of 2, at least 4.
REQ-002 Parameter SKIP, default 0, decoded bits discarded after start (traceback warm-up).
REQ-003 Parameter WINDOW, default 256, compared bits per measurement; range 1 to 2**CW-1.
REQ-004 Parameter CW, default 16, counter width.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  one-cycle pulse; clears the checker and begins a measurement.
REQ-008 ref_bit_i  input  1  original message bit fed to the encoder.
REQ-009 ref_valid_i  input  1  ref_bit_i is valid this cycle.
REQ-010 dec_bit_i  input  1  decoder output bit.
REQ-011 dec_valid_i  input  1  dec_bit_i is valid this cycle.
REQ-012 bit_ct_o  output  CW  compared-bit count.
REQ-013 err_ct_o  output  CW  mismatched-bit count.
REQ-014 err_pulse_o  output  1  one-cycle pulse per mismatch.
REQ-015 done_o  output  1  high while in DONE.
REQ-016 fifo_ovf_o  output  1  sticky flag: a reference bit was dropped.
REQ-017 fifo_unf_o  output  1  sticky flag: a decoded bit arrived with no reference bit available.

Function
REQ-018 The state machine SHALL have states IDLE, SYNC, RUN and DONE; all outputs SHALL be registered.
REQ-019 In any state, start_i SHALL clear the FIFO, all counters and all flags; the next state SHALL be SYNC, or RUN when SKIP=0.
REQ-020 In SYNC and RUN, ref_valid_i SHALL push ref_bit_i; pushes SHALL be ignored in IDLE and DONE.
REQ-021 In SYNC and RUN, dec_valid_i SHALL pop one entry.
REQ-022 In SYNC, popped entries SHALL be discarded; after SKIP pops the state SHALL move to RUN.
REQ-023 In RUN, each pop SHALL compare the FIFO head with dec_bit_i. On the next edge:
  - bit_ct_o increments by 1.
  - err_ct_o increments by 1 on a mismatch.
  - err_pulse_o is high for exactly 1 cycle on a mismatch.
REQ-024 When bit_ct_o reaches WINDOW, the state SHALL become DONE on the same edge, with done_o high from that edge.
REQ-025 In DONE, counters SHALL hold and inputs other than start_i SHALL be ignored.
REQ-026 Full FIFO, push without a simultaneous pop: the bit SHALL be dropped and fifo_ovf_o set. Push and pop together when full SHALL both succeed.
REQ-027 Pop from an empty FIFO SHALL set fifo_unf_o and SHALL NOT count or compare, even with a simultaneous push; that pushed bit SHALL be stored.
REQ-028 Counters SHALL saturate at 2**CW-1; the FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While rst is low, the block SHALL be in IDLE with the FIFO empty and every output at 0, independent of clk.
REQ-030 rst asserted mid-measurement SHALL abandon the measurement; after release the block SHALL remain in IDLE until start_i.

Configuration
REQ-031 When BER_BURST_STATS_EN is defined, the block SHALL add output max_burst_o (width CW).
  - max_burst_o is the longest run of consecutive mismatches compared in RUN.
  - A match ends a run.
  - max_burst_o is cleared by start_i and by rst, and saturates at 2**CW-1.
REQ-032 When BER_BURST_STATS_EN is undefined, port max_burst_o and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Clean loop: SKIP=0, WINDOW=256, decoded bits equal reference bits delayed 20 cycles -> bit_ct_o=256, err_ct_o=0, done_o=1, both flags 0.
REQ-034 Errors: flip decoded bits 10, 11, 12 and 100 -> err_ct_o=4, four err_pulse_o pulses; with the macro, max_burst_o=3.
REQ-035 Warm-up: SKIP=5, first 5 decoded bits all wrong -> err_ct_o=0, bit_ct_o=WINDOW.
REQ-036 Overflow: DEPTH=64, 70 pushes with no pops -> fifo_ovf_o=1 and the FIFO holds the first 64 bits.
REQ-037 Underflow and restart:
  - dec_valid_i before any ref_valid_i -> fifo_unf_o=1 and bit_ct_o=0.
  - A start_i pulse then clears all outputs.
REQ-038 rst pulsed low mid-RUN -> all outputs 0 immediately; the block stays in IDLE until start_i.
